// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the word-buffer read side: word width and FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_reader_pkg;

    // Buffer word width, shared with the write side of the async buffer.
    localparam int DATA_W = 16;

    // Read-side FSM encodings.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_POP   = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

endpackage

// File: rtl/fifo_reader_dwell_counter.sv
// Dwell counter: loadable down-counter with a zero flag, stops at zero.
// Latency: load/decrement visible the cycle after the strobe; zero is combinational on the count.
// Backpressure: none; the owner decides when to load or decrement.
module dwell_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement saturates at zero so an extra dec is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_reader.sv
// Buffer read side: pops one word, shows it on data_2 for DWELL_BASE<<prog cycles, repeats.
// Latency: rd_empty low sampled at edge N -> data_2_valid high after edge N+2.
// Backpressure: pops only when rd_empty=0; drain cuts the dwell short. Optional parity: FIFO_READER_PARITY_EN.
module fifo_reader #(
    parameter int DATA_W     = fifo_reader_pkg::DATA_W,
    parameter int DWELL_BASE = 1000,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    input  logic [2:0]        prog,
    input  logic              drain,
    output logic [DATA_W-1:0] data_2,
    output logic              data_2_valid,
    output logic              busy,
    output logic [7:0]        word_cnt,
    output logic              parity
);

    import fifo_reader_pkg::*;

    logic [1:0]       state;
    logic [CNT_W-1:0] dwell_len;
    logic [CNT_W-1:0] dwell_load_val;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    // prog is only looked at in S_LATCH, so changes mid-dwell apply to the next word.
    assign dwell_len      = CNT_W'(DWELL_BASE) << prog;
    assign dwell_load_val = drain ? '0 : (dwell_len - 1'b1);
    assign cnt_load       = (state == S_LATCH);
    assign cnt_dec        = (state == S_HOLD) && !cnt_zero && !drain;

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (dwell_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Pop strobe and busy come from state alone, so an empty buffer can never be popped.
    assign rd_en = (state == S_POP);
    assign busy  = (state != S_IDLE);

    // Read FSM: idle -> pop -> latch word -> hold for the dwell -> idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            data_2       <= '0;
            data_2_valid <= 1'b0;
            word_cnt     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rd_empty) begin
                        state <= S_POP;
                    end
                end
                S_POP: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    data_2       <= rd_data;
                    data_2_valid <= 1'b1;
                    word_cnt     <= word_cnt + 8'd1;
                    state        <= S_HOLD;
                end
                S_HOLD: begin
                    if (cnt_zero || drain) begin
                        data_2_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_READER_PARITY_EN
    // Parity of the displayed word, loaded together with data_2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else if (state == S_LATCH) begin
            parity <= ^rd_data;
        end
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    localparam int DW = 16;
    localparam int DB = 4;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_empty = 1'b1;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en;
    logic [2:0]    prog = 3'd0;
    logic          drain = 1'b0;
    logic [DW-1:0] data_2;
    logic          data_2_valid;
    logic          busy;
    logic [7:0]    word_cnt;
    logic          parity;

    fifo_reader #(
        .DATA_W     (DW),
        .DWELL_BASE (DB),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_empty     (rd_empty),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .prog         (prog),
        .drain        (drain),
        .data_2       (data_2),
        .data_2_valid (data_2_valid),
        .busy         (busy),
        .word_cnt     (word_cnt),
        .parity       (parity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dat;
        int            dwell;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo_q[$];
    int            checks = 0;
    int            failures = 0;
    int            pushed = 0;
    int            popped = 0;
    logic          prev_rd_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of time plus the buffer model: a pop seen during the rd_en cycle
    // puts the head word on rd_data for the following cycle.
    task automatic tick();
        @(negedge clk);
        if (rst && rd_en) begin
            check("rd_en_nonempty", (fifo_q.size() != 0), 1);
            check("rd_en_single_cycle", prev_rd_en, 0);
            if (fifo_q.size() != 0) begin
                rd_data = fifo_q.pop_front();
                popped++;
            end
        end
        prev_rd_en = rd_en;
        rd_empty   = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] d, input int dwell, input bit expect_it);
        exp_t e;
        fifo_q.push_back(d);
        rd_empty = 1'b0;
        pushed++;
        if (expect_it) begin
            e.dat   = d;
            e.dwell = dwell;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(rd_empty && !busy && !data_2_valid) && n < budget);
        check("idle_reached", (rd_empty && !busy && !data_2_valid), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!data_2_valid && n < budget);
        check("valid_seen", data_2_valid, 1);
    endtask

    // Monitor: each data_2_valid window is one delivered word; compare against the scoreboard.
    logic [7:0] wc_model = 8'd0;
    bit         in_win = 0;
    bit         have_prev = 0;
    int         win_len = 0;
    int         gap = 0;
    exp_t       cur;

    always @(negedge clk) begin
        if (!rst) begin
            in_win    = 0;
            have_prev = 0;
            wc_model  = 8'd0;
            win_len   = 0;
            gap       = 0;
        end else if (data_2_valid && !in_win) begin
            wc_model = wc_model + 8'd1;
            if (sb.size() == 0) begin
                check("unexpected_window", 1, 0);
                cur.dat   = data_2;
                cur.dwell = 0;
            end else begin
                cur = sb.pop_front();
                check("data_2", data_2, cur.dat);
            end
            check("word_cnt", word_cnt, wc_model);
`ifdef FIFO_READER_PARITY_EN
            check("parity", parity, ^cur.dat);
`else
            check("parity", parity, 0);
`endif
            if (have_prev) check("gap_at_least_3", (gap >= 3), 1);
            in_win  = 1;
            win_len = 1;
        end else if (data_2_valid) begin
            win_len++;
            check("busy_in_dwell", busy, 1);
        end else if (in_win) begin
            check("dwell_len", win_len, cur.dwell);
            check("data_2_held", data_2, cur.dat);
            in_win    = 0;
            have_prev = 1;
            gap       = 1;
        end else begin
            gap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a non-empty buffer: outputs stay zero, nothing popped.
        rst = 1'b0;
        push(16'h1234, 0, 0);
        repeat (6) begin
            tick();
            check("rst_rd_en", rd_en, 0);
        end
        check("rst_data_2", data_2, 0);
        check("rst_valid", data_2_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_parity", parity, 0);
        fifo_q.delete();
        pushed   = 0;
        rd_empty = 1'b1;
        rst      = 1'b1;
        tick();

        // Single word, prog=1 -> 8-cycle dwell.
        prog = 3'd1;
        push(16'hA5A5, DB << 1, 1);
        wait_idle(100);

        // Three preloaded words, prog=0 -> 4-cycle dwells, spaced >= 3 cycles.
        prog = 3'd0;
        push(16'h0001, DB, 1);
        push(16'h0002, DB, 1);
        push(16'h0003, DB, 1);
        wait_idle(200);
        check("last_word_held", data_2, 16'h0003);
        check("word_cnt_after_three", word_cnt, 4);

        // drain in the first dwell cycle ends the window after one cycle.
        push(16'h0007, 1, 1);
        wait_valid(50);
        drain = 1'b1;
        tick();
        check("drain_valid_fall", data_2_valid, 0);
        drain = 1'b0;
        wait_idle(50);
        check("drained_busy", busy, 0);
        check("drained_empty", rd_empty, 1);

        // prog change mid-dwell only affects the next word.
        prog = 3'd0;
        push(16'h0055, DB, 1);
        push(16'h00AA, DB << 7, 1);
        wait_valid(50);
        prog = 3'd7;
        wait_idle(800);
        prog = 3'd0;

        // Reset during S_LATCH discards the popped word; no re-pop afterwards.
        push(16'hBEEF, 0, 0);
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (!rd_en && n < 50);
            check("pop_seen", rd_en, 1);
        end
        tick();
        rst = 1'b0;
        #1;
        check("midrst_data_2", data_2, 0);
        check("midrst_word_cnt", word_cnt, 0);
        check("midrst_valid", data_2_valid, 0);
        check("midrst_busy", busy, 0);
        tick();
        rst = 1'b1;
        repeat (10) begin
            tick();
            check("no_repop", rd_en, 0);
        end
        push(16'h0F0F, DB, 1);
        wait_idle(100);

        // Randomized batches with random prog and spacing.
        for (int b = 0; b < 8; b++) begin
            int n;
            prog = 3'($urandom_range(0, 2));
            n    = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                push(16'($urandom), DB << prog, 1);
                repeat ($urandom_range(0, 6)) tick();
            end
            wait_idle(400);
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        check("all_words_popped", popped, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
